// File: rtl/fsqrt_iter.sv
// Multi-cycle binary32 square root using restoring digit recurrence,
// BITS_PER_CYCLE root bits per CALC cycle, RNE rounding, valid/ready on both sides.
module fsqrt_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        exception
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int N     = (25 + BPC - 1) / BPC;
    localparam int TOT   = N * BPC;      // root bits produced, including surplus
    localparam int RAD_W = 2 * TOT;
    localparam int RW    = TOT + 3;      // remainder < 2*root+1, plus two shifted-in bits
    localparam int CW    = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RAD_W-1:0] rad_q, rad_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [TOT-1:0]   root_q, root_d;
    logic [7:0]       exp_q, exp_d;
    logic             spec_q, spec_d;
    logic [31:0]      spec_y_q, spec_y_d;
    logic             spec_exc_q, spec_exc_d;
    logic [31:0]      y_q, y_d;
    logic             exc_q, exc_d;

    logic             accept;
    logic             x_sgn;
    logic [7:0]       x_exp;
    logic [22:0]      x_frac;
    logic             is_spec;
    logic [31:0]      cls_y;
    logic             cls_exc;
    logic [49:0]      rad50;
    logic [7:0]       exp_init;

    assign accept = in_valid && (state_q == IDLE);
    assign x_sgn  = x[31];
    assign x_exp  = x[30:23];
    assign x_frac = x[22:0];

    always_comb begin
        is_spec = x_sgn || (x_exp == 8'hFF) || (x_exp == 8'h00);
        cls_exc = x_sgn || (x_exp == 8'hFF);
        if (x_sgn)                cls_y = 32'h7FC00000;
        else if (x_exp == 8'hFF)  cls_y = (x_frac != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
        else                      cls_y = 32'h00000000;
        if (x_exp[0]) begin
            rad50    = {1'b0, 1'b1, x_frac, 25'd0};
            exp_init = 8'((9'(x_exp) + 9'd127) >> 1);
        end else begin
            rad50    = {1'b1, x_frac, 26'd0};
            exp_init = 8'((9'(x_exp) + 9'd126) >> 1);
        end
    end

    logic [RAD_W-1:0] it_rad, rd;
    logic [RW-1:0]    it_rem, r, t;
    logic [TOT-1:0]   it_root, q;

    always_comb begin
        r = rem_q;
        q = root_q;
        rd = rad_q;
        t = '0;
        for (int k = 0; k < BPC; k++) begin
            r = {r[RW-3:0], rd[RAD_W-1 -: 2]};
            rd = {rd[RAD_W-3:0], 2'b00};
            t = '0;
            t[TOT+1:0] = {q, 2'b01};
            if (r >= t) begin
                r = r - t;
                q = {q[TOT-2:0], 1'b1};
            end else begin
                q = {q[TOT-2:0], 1'b0};
            end
        end
        it_rem  = r;
        it_root = q;
        it_rad  = rd;
    end

    logic [24:0]    root25;
    logic [TOT-1:0] low_bits;
    logic           sticky, rnd_inc;
    logic [24:0]    sig_rnd;
    logic [31:0]    rnd_y;

    always_comb begin
        root25   = 25'(root_q >> (TOT - 25));
        low_bits = root_q ^ (TOT'(root25) << (TOT - 25));
        sticky   = (rem_q != '0) || (low_bits != '0);
        rnd_inc  = root25[0] && (sticky || root25[1]);
        sig_rnd  = {1'b0, root25[24:1]} + 25'(rnd_inc);
        // Hidden bit lands on the exponent LSB, so bias the exponent down by one;
        // a rounding carry then bumps the exponent and leaves the fraction zero.
        rnd_y    = {1'b0, exp_q - 8'd1, 23'd0} + 32'(sig_rnd);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = is_spec ? ROUND : CALC;
            CALC:  if (cnt_q == CW'(N - 1)) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d      = cnt_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        exp_d      = exp_q;
        spec_d     = spec_q;
        spec_y_d   = spec_y_q;
        spec_exc_d = spec_exc_q;
        y_d        = y_q;
        exc_d      = exc_q;
        if (accept) begin
            cnt_d      = '0;
            rad_d      = RAD_W'(rad50) << (RAD_W - 50);
            rem_d      = '0;
            root_d     = '0;
            exp_d      = exp_init;
            spec_d     = is_spec;
            spec_y_d   = cls_y;
            spec_exc_d = cls_exc;
        end else if (state_q == CALC) begin
            cnt_d  = cnt_q + CW'(1);
            rad_d  = it_rad;
            rem_d  = it_rem;
            root_d = it_root;
        end else if (state_q == ROUND) begin
            y_d   = spec_q ? spec_y_q : rnd_y;
            exc_d = spec_q && spec_exc_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            exp_q      <= '0;
            spec_q     <= 1'b0;
            spec_y_q   <= '0;
            spec_exc_q <= 1'b0;
            y_q        <= '0;
            exc_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            exp_q      <= exp_d;
            spec_q     <= spec_d;
            spec_y_q   <= spec_y_d;
            spec_exc_q <= spec_exc_d;
            y_q        <= y_d;
            exc_q      <= exc_d;
        end
    end

    assign y         = y_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_fsqrt_iter.sv
// Bench for fsqrt_iter: one instance per BITS_PER_CYCLE value, scoreboard of
// expected {exception, y}, directed cases plus random normals against $sqrt.
module tb_fsqrt_iter;
    logic        clk, rstn;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] x        [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [31:0] y        [3];
    logic        exception[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fsqrt_iter #(.BITS_PER_CYCLE(g + 1)) u_dut (
            .clk(clk), .rstn(rstn),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .x(x[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .y(y[g]), .exception(exception[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ntests = 0;
    int          nfail  = 0;
    logic [32:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int nof(input int d);
        return (25 + d) / (d + 1);
    endfunction

    // Reference: exact double sqrt, then RNE to single.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        logic [63:0] db;
        logic        inc;
        db  = {1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db  = $realtobits($sqrt($bitstoreal(db)));
        inc = db[28] && ((|db[27:0]) || db[29]);
        return {1'b0, 8'(db[62:52] - 11'd896), db[51:29]} + 32'(inc);
    endfunction

    task automatic pop_check(input int d, input string tag);
        logic [32:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_y"}, 64'(y[d]), 64'(e[31:0]));
            check({tag, "_exc"}, 64'(exception[d]), 64'(e[32]));
        end
    endtask

    // One operation with out_ready high; latency counted in edges incl. the accept edge.
    task automatic do_op(input int d, input logic [31:0] xv, input logic [32:0] ev,
                         input int lat, input string tag);
        int n;
        check({tag, "_rdy_pre"}, 64'(in_ready[d]), 64'd1);
        sb.push_back(ev);
        x[d] = xv;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        n = 1;
        check({tag, "_rdy_busy"}, 64'(in_ready[d]), 64'd0);
        while (!out_valid[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        pop_check(d, tag);
        @(negedge clk);
        check({tag, "_rdy_post"}, 64'(in_ready[d]), 64'd1);
    endtask

    logic [31:0] sp_x[5] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h00000001};
    logic [32:0] sp_e[5] = '{{1'b1, 32'h7FC00000}, {1'b1, 32'h7FC00000}, {1'b1, 32'h7F800000},
                             {1'b1, 32'h7FC00000}, {1'b0, 32'h00000000}};
    logic [31:0] bb_x[3] = '{32'h40800000, 32'h41100000, 32'h40000000};
    logic [31:0] bb_y[3] = '{32'h40000000, 32'h40400000, 32'h3FB504F3};

    initial begin
        logic [31:0] rx, hold_y;
        int          n, got, last, k;
        logic        acc, spurious;

        rstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; x[d] = '0; out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", 64'(out_valid[d]), 64'd0);
            check("rst_y", 64'(y[d]), 64'd0);
            check("rst_exc", 64'(exception[d]), 64'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("rst_in_ready", 64'(in_ready[d]), 64'd1);

        for (int d = 0; d < 3; d++) begin
            do_op(d, 32'h40800000, {1'b0, 32'h40000000}, nof(d) + 2, "sqrt4");
            do_op(d, 32'h40000000, {1'b0, 32'h3FB504F3}, nof(d) + 2, "sqrt2");
            do_op(d, 32'h3F800000, {1'b0, 32'h3F800000}, nof(d) + 2, "sqrt1");
            do_op(d, 32'h41100000, {1'b0, 32'h40400000}, nof(d) + 2, "sqrt9");
            do_op(d, 32'h7F7FFFFF, {1'b0, 32'h5F7FFFFF}, nof(d) + 2, "sqrtmax");
            do_op(d, 32'h00800000, {1'b0, 32'h20000000}, nof(d) + 2, "sqrtmin");
            for (int i = 0; i < 5; i++) do_op(d, sp_x[i], sp_e[i], 2, "special");
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 150; i++) begin
                rx = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
                do_op(d, rx, {1'b0, ref_sqrt(rx)}, nof(d) + 2, "random");
            end
        end

        // Backpressure on the 3-bit instance; a second pulse while in DONE must be ignored.
        out_ready[2] = 1'b0;
        sb.push_back({1'b0, 32'h40000000});
        x[2] = 32'h40800000;
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        n = 1;
        while (!out_valid[2] && n < 200) begin @(negedge clk); n++; end
        check("bp_lat", 64'(n), 64'(nof(2) + 2));
        pop_check(2, "bp");
        hold_y = 32'h40000000;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin x[2] = 32'h3F800000; in_valid[2] = 1'b1; end
            if (i == 6) in_valid[2] = 1'b0;
            @(negedge clk);
            check("bp_y_stable", 64'(y[2]), 64'(hold_y));
            check("bp_in_ready", 64'(in_ready[2]), 64'd0);
            check("bp_out_valid", 64'(out_valid[2]), 64'd1);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", 64'(in_ready[2]), 64'd1);
        check("bp_release_vld", 64'(out_valid[2]), 64'd0);
        spurious = 1'b0;
        repeat (15) begin @(negedge clk); if (out_valid[2]) spurious = 1'b1; end
        check("bp_second_ignored", 64'(spurious), 64'd0);

        // Reset five cycles into CALC aborts the operation.
        x[0] = 32'h40000000;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rstmid_out_valid", 64'(out_valid[0]), 64'd0);
        check("rstmid_in_ready", 64'(in_ready[0]), 64'd1);
        spurious = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid[0]) spurious = 1'b1; end
        check("rstmid_no_result", 64'(spurious), 64'd0);
        do_op(0, 32'h40800000, {1'b0, 32'h40000000}, nof(0) + 2, "rstmid_after");

        // Back-to-back stream with in_valid held high.
        for (int d = 0; d < 3; d++) begin
            k = 0; got = 0; last = 0;
            x[d] = bb_x[0];
            in_valid[d] = 1'b1;
            for (int cyc = 0; cyc < 400 && got < 3; cyc++) begin
                acc = in_ready[d] && in_valid[d];
                if (acc) sb.push_back({1'b0, bb_y[k]});
                @(negedge clk);
                if (acc) begin
                    k++;
                    if (k < 3) x[d] = bb_x[k];
                    else in_valid[d] = 1'b0;
                end
                if (out_valid[d]) begin
                    pop_check(d, "b2b");
                    if (got > 0) check("b2b_spacing", 64'(cyc - last), 64'(nof(d) + 3));
                    last = cyc;
                    got++;
                end
            end
            in_valid[d] = 1'b0;
            check("b2b_count", 64'(got), 64'd3);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
